// File: rtl/clk_phase_gen.sv
`default_nettype none
// ============================================================================
//  Module   : clk_phase_gen
//  Purpose  : N-phase clock sequencer. Rotates a one-hot phase vector over a
//             run-time programmable number of phases, with stall, a
//             run/drain/idle handshake, and glitch-free per-phase gated
//             clocks that a test mode can force to follow clk.
//  Revision : 1.0  initial release
// ============================================================================
module clk_phase_gen #(
  parameter int NPH = 4,
  parameter int IW  = $clog2(NPH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           run,
  input  logic           stall,
  input  logic [IW:0]    nphase,
  input  logic           test,
  output logic [NPH-1:0] ph,
  output logic [IW-1:0]  phidx,
  output logic [NPH-1:0] gclk,
  output logic           wrap,
  output logic           busy
);

  localparam logic [IW:0] C_NPH = (IW+1)'(NPH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [IW-1:0]  idx_d;
  logic [IW:0]    nph_q;
  logic [IW:0]    nph_d;
  logic [IW:0]    nph_clamped;
  logic           is_last;
  logic [NPH-1:0] en;

  // Out-of-range requests (0 or above NPH) fall back to the full phase count.
  assign nph_clamped = ((nphase == '0) || (nphase > C_NPH)) ? C_NPH : nphase;

  assign is_last = ({1'b0, phidx} == (nph_q - 1'b1));
  assign busy    = (state_q != S_IDLE);
  assign wrap    = busy & ~stall & is_last;

  // Next-state, next phase index and phase-count reload.
  always_comb begin
    state_d = state_q;
    idx_d   = phidx;
    nph_d   = nph_q;
    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (run) begin
          state_d = S_RUN;
          nph_d   = nph_clamped;
        end
      end
      S_RUN, S_DRAIN: begin
        if (!stall) begin
          idx_d = is_last ? '0 : phidx + 1'b1;
        end
        if (wrap) begin
          nph_d = nph_clamped;
        end
        // A run request during drain resumes rotation seamlessly; without it
        // the sequencer parks at the end of the current rotation.
        if (run) begin
          state_d = S_RUN;
        end else if (wrap) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Sequencer state registers; ph is registered alongside phidx so it never
  // has a combinational path from the inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      phidx   <= '0;
      ph      <= {{(NPH-1){1'b0}}, 1'b1};
      nph_q   <= C_NPH;
    end else begin
      state_q <= state_d;
      phidx   <= idx_d;
      ph      <= {{(NPH-1){1'b0}}, 1'b1} << idx_d;
      nph_q   <= nph_d;
    end
  end

  assign en = {NPH{test}} | (ph & {NPH{busy & ~stall}});

  // Latch-based clock gates: the enable is captured while clk is low so each
  // gated clock can only pulse during the clk high phase. The latch is also
  // transparent in reset so a gate drops (or follows test) immediately.
  generate
    for (genvar i = 0; i < NPH; i++) begin : g_gate
      logic en_q;

      // Gate-enable latch, open while clk is low or reset is asserted.
      always_latch begin
        if (!clk || reset) begin
          en_q <= en[i];
        end
      end

      assign gclk[i] = clk & en_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_clk_phase_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clk_phase_gen
//  Purpose  : Directed self-checking bench for clk_phase_gen (NPH=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_clk_phase_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic       stall;
  logic [2:0] nphase;
  logic       test;
  logic [3:0] ph;
  logic [1:0] phidx;
  logic [3:0] gclk;
  logic       wrap;
  logic       busy;

  int checks = 0;
  int errors = 0;

  clk_phase_gen #(.NPH(4), .IW(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .run    (run),
    .stall  (stall),
    .nphase (nphase),
    .test   (test),
    .ph     (ph),
    .phidx  (phidx),
    .gclk   (gclk),
    .wrap   (wrap),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called in the clk low phase: checks the current cycle's outputs, then
  // crosses one rising edge and checks the gated clocks in the high phase.
  task automatic tick(input int idx, input bit b, input bit w);
    logic [3:0] exp_g;
    logic [3:0] onehot;
    #1;
    onehot = 4'b0001 << idx;
    chk("phidx", 32'(phidx), 32'(idx));
    chk("ph", 32'(ph), 32'(onehot));
    chk("busy", 32'(busy), 32'(b));
    chk("wrap", 32'(wrap), 32'(w));
    chk("gclk_low", 32'(gclk), 32'h0);
    exp_g = test ? 4'hf : ((b && !stall) ? onehot : 4'h0);
    @(posedge clk);
    #1;
    chk("gclk_high", 32'(gclk), 32'(exp_g));
    @(negedge clk);
  endtask

  initial begin
    // Reset together with a run request: reset must win.
    reset = 1'b1; run = 1'b1; stall = 1'b0; nphase = 3'd4; test = 1'b0;
    @(negedge clk); #1;
    chk("rst_ph", 32'(ph), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    @(posedge clk); #1;
    chk("rst_gclk", 32'(gclk), 32'h0);
    chk("rst_run_busy", 32'(busy), 32'h0);
    @(negedge clk);
    run = 1'b0; reset = 1'b0;

    // 1. Idle
    for (int k = 0; k < 5; k++) tick(0, 0, 0);

    // 2. Three-phase rotation
    nphase = 3'd3; run = 1'b1;
    tick(0, 0, 0);
    tick(0, 1, 0); tick(1, 1, 0); tick(2, 1, 1);
    tick(0, 1, 0); tick(1, 1, 0);
    nphase = 3'd4;                 // reloaded on the coming wrap
    tick(2, 1, 1);

    // 3. Stall at phidx=1, then stall on the would-be wrap cycle
    tick(0, 1, 0);
    stall = 1'b1; tick(1, 1, 0); tick(1, 1, 0);
    stall = 1'b0; tick(1, 1, 0); tick(2, 1, 0);
    stall = 1'b1; tick(3, 1, 0);
    stall = 1'b0; tick(3, 1, 1);
    tick(0, 1, 0);

    // 4. Drain to idle, then drain interrupted by run
    run = 1'b0; tick(1, 1, 0); tick(2, 1, 0); tick(3, 1, 1);
    tick(0, 0, 0);
    run = 1'b1; tick(0, 0, 0);
    tick(0, 1, 0);
    run = 1'b0; tick(1, 1, 0);
    run = 1'b1; tick(2, 1, 0); tick(3, 1, 1); tick(0, 1, 0);

    // 5. Phase-count change only at wrap; nphase=0 and >NPH clamp; nph_q=1
    nphase = 3'd2;
    tick(1, 1, 0); tick(2, 1, 0); tick(3, 1, 1);
    tick(0, 1, 0); tick(1, 1, 1); tick(0, 1, 0);
    nphase = 3'd0;
    tick(1, 1, 1);
    tick(0, 1, 0); tick(1, 1, 0); tick(2, 1, 0);
    nphase = 3'd1;
    tick(3, 1, 1);
    tick(0, 1, 1); tick(0, 1, 1);
    stall = 1'b1; tick(0, 1, 0);
    stall = 1'b0; nphase = 3'd5;
    tick(0, 1, 1);
    tick(0, 1, 0); tick(1, 1, 0); tick(2, 1, 0); tick(3, 1, 1);

    // 6. Asynchronous reset mid-rotation at phidx=2, test override
    tick(0, 1, 0); tick(1, 1, 0);
    #2 reset = 1'b1;
    #1;
    chk("arst_ph", 32'(ph), 32'h1);
    chk("arst_phidx", 32'(phidx), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    @(posedge clk); #1;
    chk("arst_gclk", 32'(gclk), 32'h0);
    @(negedge clk);
    test = 1'b1; #1;
    chk("test_rst_low", 32'(gclk), 32'h0);
    @(posedge clk); #1;
    chk("test_rst_high", 32'(gclk), 32'hf);
    @(negedge clk);
    reset = 1'b0; run = 1'b0;
    tick(0, 0, 0); tick(0, 0, 0);
    run = 1'b1; tick(0, 0, 0); tick(0, 1, 0);
    test = 1'b0; run = 1'b0;
    tick(1, 1, 0); tick(2, 1, 0); tick(3, 1, 1); tick(0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Overall time bound so the run always terminates.
  initial begin
    #100000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
